// File: rtl/bmu_issue_ctrl.sv
// bmu_issue_ctrl: buffers tagged BMU requests, issues them one at a time, returns tagged results in order.
// Latency: accept in cycle 0, IDLE pop in cycle 1, ISSUE in cycle 2, CAPTURE in cycle 3, rsp_valid in cycle 4.
// Backpressure: req_ready = !fifo_full; a stalled response holds the FSM in RESP, so capacity is DEPTH + 1.
// Ports: clk/rst (sync, active-high); req_* request channel; bmu_* BMU drive and registered result;
//        rsp_* response channel; busy = FSM not IDLE or FIFO non-empty; err_cnt = error-response count.
// Optional: define BMU_ISSUE_ERR_CNT_EN to build the saturating 16-bit err_cnt (tied to 0 otherwise).
module bmu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             bmu_valid_in,
  output logic [31:0]      bmu_a_in,
  output logic [31:0]      bmu_b_in,
  output logic [22:0]      bmu_ap,
  input  logic [31:0]      bmu_result_ff,
  input  logic             bmu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  // bmu_ap bit positions (MSB csr_write = 22 ... LSB gorc = 0)
  localparam int AP_ZBB     = 20;
  localparam int AP_LAND    = 16;
  localparam int AP_LXOR    = 15;
  localparam int AP_SLL     = 14;
  localparam int AP_SRA     = 13;
  localparam int AP_BEXT    = 11;
  localparam int AP_ADD     = 9;
  localparam int AP_SLT     = 8;
  localparam int AP_UNSIGN  = 7;
  localparam int AP_SUB     = 6;
  localparam int AP_CLZ     = 5;
  localparam int AP_CPOP    = 4;
  localparam int AP_SIEXT_H = 3;
  localparam int AP_PACKU   = 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  function automatic logic [22:0] decode_ap(input logic [3:0] op);
    logic [22:0] ap;
    ap = '0;
    case (op)
      4'd0:  ap[AP_ADD] = 1'b1;
      4'd1:  ap[AP_SUB] = 1'b1;
      4'd2:  ap[AP_LAND] = 1'b1;
      4'd3:  begin ap[AP_LAND] = 1'b1; ap[AP_ZBB] = 1'b1; end
      4'd4:  ap[AP_LXOR] = 1'b1;
      4'd5:  ap[AP_SLL] = 1'b1;
      4'd6:  ap[AP_SRA] = 1'b1;
      4'd7:  ap[AP_BEXT] = 1'b1;
      4'd8:  ap[AP_SLT] = 1'b1;
      4'd9:  begin ap[AP_SLT] = 1'b1; ap[AP_UNSIGN] = 1'b1; end
      4'd10: ap[AP_CLZ] = 1'b1;
      4'd11: ap[AP_CPOP] = 1'b1;
      4'd12: ap[AP_SIEXT_H] = 1'b1;
      4'd13: ap[AP_PACKU] = 1'b1;
      default: ap = '0;
    endcase
    return ap;
  endfunction

  // ---------------- request FIFO ----------------
  entry_t         fifo_mem [DEPTH];
  entry_t         head;
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_full, fifo_empty, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  // Full is judged on registered pointers only, so a same-cycle pop never raises ready.
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {req_op, req_a, req_b, req_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------- issue FSM ----------------
  state_t      state, state_nxt;
  entry_t      op_q;
  logic [31:0] res_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        op_q  <= head;
        // An illegal opcode answers directly with result 0 / error 1; legal ones get overwritten in CAPTURE.
        res_q <= '0;
        err_q <= (head.op > 4'd13);
      end
      if (state == CAPTURE) begin
        res_q <= bmu_result_ff;
        err_q <= bmu_error;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    bmu_valid_in = 1'b0;
    bmu_a_in     = '0;
    bmu_b_in     = '0;
    bmu_ap       = '0;
    rsp_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = (head.op <= 4'd13) ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        bmu_valid_in = 1'b1;
        bmu_a_in     = op_q.a;
        bmu_b_in     = op_q.b;
        bmu_ap       = decode_ap(op_q.op);
        state_nxt    = CAPTURE;
      end
      CAPTURE: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_result = res_q;
  assign rsp_error  = err_q;
  assign rsp_tag    = op_q.tag;
  assign busy       = (state != IDLE) || !fifo_empty;

`ifdef BMU_ISSUE_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (rsp_valid && rsp_ready && rsp_error && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_bmu_issue_ctrl.sv
// tb_bmu_issue_ctrl: directed + random stimulus for bmu_issue_ctrl against a queue-based reference model.
// A behavioural BMU answers one cycle after each bmu_valid_in pulse and drives noise at all other times.
// Ports: drives every bmu_issue_ctrl port; prints one summary line at the end.
module tb_bmu_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             bmu_valid_in;
  logic [31:0]      bmu_a_in, bmu_b_in;
  logic [22:0]      bmu_ap;
  logic [31:0]      bmu_result_ff;
  logic             bmu_error;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_error;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [15:0]      err_cnt;

  always #5 clk = ~clk;

  bmu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .bmu_valid_in(bmu_valid_in), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in), .bmu_ap(bmu_ap),
    .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag), .busy(busy), .err_cnt(err_cnt)
  );

  typedef struct { logic [31:0] res; logic err; logic [TAG_W-1:0] tag; } rsp_t;
  typedef struct { logic [22:0] ap; logic [31:0] a; logic [31:0] b; } iss_t;

  rsp_t             rsp_q[$];
  iss_t             iss_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               err_model = 0;
  int               pulses   = 0;
  logic [22:0]      last_ap;
  logic             prev_stall;
  logic [31:0]      prev_res;
  logic             prev_err;
  logic [TAG_W-1:0] prev_tag;

  // One-hot of a control bit by its position in the MSB-first name list
  // (csr_write=0, csr_imm=1, zbb=2, ... land=6, lxor=7, sll=8, sra=9, rol=10, bext=11,
  //  sh3add=12, add=13, slt=14, unsign=15, sub=16, clz=17, cpop=18, siext_h=19, min=20, packu=21, gorc=22).
  function automatic logic [22:0] bit_named(input int msb_idx);
    return 23'd1 << (22 - msb_idx);
  endfunction

  function automatic logic [22:0] ap_of(input int op);
    case (op)
      0:  return bit_named(13);
      1:  return bit_named(16);
      2:  return bit_named(6);
      3:  return bit_named(6) | bit_named(2);
      4:  return bit_named(7);
      5:  return bit_named(8);
      6:  return bit_named(9);
      7:  return bit_named(11);
      8:  return bit_named(14);
      9:  return bit_named(14) | bit_named(15);
      10: return bit_named(17);
      11: return bit_named(18);
      12: return bit_named(19);
      13: return bit_named(21);
      default: return 23'd0;
    endcase
  endfunction

  // Architectural result of an opcode; error means signed overflow for ADD/SUB, and illegal opcodes.
  function automatic void ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
    r = '0;
    e = 1'b0;
    case (op)
      0:  begin r = a + b; e = (a[31] == b[31]) && (r[31] != a[31]); end
      1:  begin r = a - b; e = (a[31] != b[31]) && (r[31] != a[31]); end
      2:  r = a & b;
      3:  r = a & ~b;
      4:  r = a ^ b;
      5:  r = a << b[4:0];
      6:  r = $signed(a) >>> b[4:0];
      7:  r = {31'b0, a[b[4:0]]};
      8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  r = (a < b) ? 32'd1 : 32'd0;
      10: for (int i = 31; i >= 0; i--) begin
            if (a[i]) break;
            r = r + 32'd1;
          end
      11: for (int i = 0; i < 32; i++) r = r + {31'b0, a[i]};
      12: r = {{16{a[15]}}, a[15:0]};
      13: r = {b[31:16], a[31:16]};
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // Behavioural BMU: registered answer one cycle after a pulse, noise otherwise.
  always @(posedge clk) begin
    int          hit;
    logic [31:0] r;
    logic        e;
    hit = -1;
    for (int k = 0; k < 14; k++) if (bmu_ap == ap_of(k)) hit = k;
    if (bmu_valid_in && hit >= 0) begin
      ref_op(hit, bmu_a_in, bmu_b_in, r, e);
      bmu_result_ff <= r;
      bmu_error     <= e;
    end else begin
      bmu_result_ff <= $urandom;
      bmu_error     <= 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [15:0] exp_err_cnt();
`ifdef BMU_ISSUE_ERR_CNT_EN
    return (err_model > 65535) ? 16'hFFFF : 16'(err_model);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic monitor();
    iss_t        it;
    rsp_t        rt;
    logic [31:0] r;
    logic        e;
    check("busy", busy, rsp_q.size() != 0);
    check("err_cnt", err_cnt, exp_err_cnt());
    if (bmu_valid_in) begin
      pulses++;
      last_ap = bmu_ap;
      check("bmu_pulse_pending", iss_q.size() != 0, 1);
      if (iss_q.size() != 0) begin
        it = iss_q.pop_front();
        check("bmu_ap", bmu_ap, it.ap);
        check("bmu_a_in", bmu_a_in, it.a);
        check("bmu_b_in", bmu_b_in, it.b);
      end
    end else begin
      check("bmu_idle_zero", {bmu_ap, bmu_a_in, bmu_b_in}, 0);
    end
    if (rst) begin
      rsp_q.delete();
      iss_q.delete();
      err_model  = 0;
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall)
      check("rsp_hold", {rsp_valid, rsp_result, rsp_error, rsp_tag}, {1'b1, prev_res, prev_err, prev_tag});
    if (rsp_valid) begin
      check("rsp_expected", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        rt = rsp_q[0];
        check("rsp_result", rsp_result, rt.res);
        check("rsp_error", rsp_error, rt.err);
        check("rsp_tag", rsp_tag, rt.tag);
        if (rsp_ready) begin
          void'(rsp_q.pop_front());
          if (rt.err) err_model++;
        end
      end
    end
    if (req_valid && req_ready) begin
      ref_op(int'(req_op), req_a, req_b, r, e);
      rt.res = r; rt.err = e; rt.tag = req_tag;
      rsp_q.push_back(rt);
      if (req_op <= 4'd13) begin
        it.ap = ap_of(int'(req_op)); it.a = req_a; it.b = req_b;
        iss_q.push_back(it);
      end
    end
    prev_stall = rsp_valid && !rsp_ready;
    prev_res   = rsp_result;
    prev_err   = rsp_error;
    prev_tag   = rsp_tag;
  endtask

  task automatic drive(input logic rv, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic rr, input logic r);
    @(negedge clk);
    rst = r; req_valid = rv; req_op = op; req_a = a; req_b = b; req_tag = tag; rsp_ready = rr;
    #1;
    cyc++;
    monitor();
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 4'd0, '0, '0, '0, rr, 1'b0);
  endtask

  task automatic wait_rsp(input int t0, output logic [31:0] res, output logic err,
                          output logic [TAG_W-1:0] tag, output int lat);
    bit found = 1'b0;
    res = '0; err = 1'b0; tag = '0; lat = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      idle(1'b1);
      if (rsp_valid) begin
        found = 1'b1; res = rsp_result; err = rsp_error; tag = rsp_tag; lat = cyc - t0;
      end
    end
    check("rsp_timeout", found, 1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && rsp_q.size() != 0; i++) idle(1'b1);
    check(name, 64'(rsp_q.size()), 0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0]      res;
    logic             err;
    logic [TAG_W-1:0] tag;
    int               lat, t0, p0, acc, got;
    logic [31:0]      r2[2];
    logic [TAG_W-1:0] g2[2];
    int               c2[2];

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b0;
    prev_stall = 1'b0; last_ap = '0; prev_res = '0; prev_err = 1'b0; prev_tag = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_bmu_valid", bmu_valid_in, 0);
    check("rst_bmu_ap", bmu_ap, 0);
    check("rst_bmu_ab", {bmu_a_in, bmu_b_in}, 0);
    check("rst_busy", busy, 0);
    check("rst_err_cnt", err_cnt, 0);

    // ADD overflow: single pulse, add bit only, rsp 4 cycles after acceptance
    p0 = pulses;
    drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 1'b1, 1'b0);
    t0 = cyc;
    wait_rsp(t0, res, err, tag, lat);
    check("add_latency", 64'(lat), 4);
    check("add_result", res, 32'h8000_0000);
    check("add_error", err, 1);
    check("add_tag", tag, 3);
    check("add_pulses", 64'(pulses - p0), 1);
    check("add_ap", last_ap, bit_named(13));

    // ANDN
    drive(1'b1, 4'd3, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd5, 1'b1, 1'b0);
    t0 = cyc;
    wait_rsp(t0, res, err, tag, lat);
    check("andn_ap", last_ap, bit_named(6) | bit_named(2));
    check("andn_result", res, 32'hF000_F000);
    check("andn_error", err, 0);

    // SLT then SLTU back to back: in order, tags kept, one response per 4 cycles
    drive(1'b1, 4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 4'd1, 1'b1, 1'b0);
    drive(1'b1, 4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 4'd2, 1'b1, 1'b0);
    got = 0;
    for (int i = 0; i < 30 && got < 2; i++) begin
      idle(1'b1);
      if (rsp_valid) begin r2[got] = rsp_result; g2[got] = rsp_tag; c2[got] = cyc; got++; end
    end
    check("slt_count", 64'(got), 2);
    if (got == 2) begin
      check("slt_result", r2[0], 1);
      check("slt_tag", g2[0], 1);
      check("sltu_result", r2[1], 0);
      check("sltu_tag", g2[1], 2);
      check("b2b_interval", 64'(c2[1] - c2[0]), 4);
    end

    // Illegal opcode after a fresh reset: no pulse, result 0, error 1
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b1);
    p0 = pulses;
    drive(1'b1, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9, 1'b1, 1'b0);
    t0 = cyc;
    wait_rsp(t0, res, err, tag, lat);
    check("ill_result", res, 0);
    check("ill_error", err, 1);
    check("ill_tag", tag, 9);
    check("ill_pulses", 64'(pulses - p0), 0);
    idle(1'b1);
`ifdef BMU_ISSUE_ERR_CNT_EN
    check("ill_err_cnt", err_cnt, 1);
`else
    check("ill_err_cnt", err_cnt, 0);
`endif

    // Stall the response channel and stream XORs: DEPTH+1 acceptances, then drain in order
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 4'd4, $urandom, $urandom, 4'(i), 1'b0, 1'b0);
      if (req_ready) acc++;
    end
    check("stall_accepts", 64'(acc), DEPTH + 1);
    check("stall_ready", req_ready, 0);
    drain("stall_drain");

    // Reset while in CAPTURE with two requests queued
    idle(1'b1);
    drive(1'b1, 4'd0, 32'd10, 32'd20, 4'd1, 1'b1, 1'b0);
    drive(1'b1, 4'd1, 32'd30, 32'd5, 4'd2, 1'b1, 1'b0);
    drive(1'b1, 4'd4, 32'd7, 32'd9, 4'd3, 1'b1, 1'b0);
    check("pre_rst_capture_busy", busy, 1);
    drive(1'b0, 4'd0, '0, '0, '0, 1'b1, 1'b1);
    idle(1'b1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_bmu_valid", bmu_valid_in, 0);
    check("post_rst_req_ready", req_ready, 1);
    repeat (6) idle(1'b1);
    drive(1'b1, 4'd11, 32'h0000_F00F, 32'h0, 4'd7, 1'b1, 1'b0);
    t0 = cyc;
    wait_rsp(t0, res, err, tag, lat);
    check("cpop_result", res, 8);
    check("cpop_tag", tag, 7);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
            TAG_W'($urandom), 1'($urandom_range(0, 9) < 7), 1'b0);
    end
    drain("final_drain");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/bmu_issue_ctrl.md
# bmu_issue_ctrl

Initiator-side front end for the bit-manipulation unit (BMU). Accepts tagged operation requests over a valid/ready interface and buffers them in a small FIFO. Decodes each opcode into the BMU's one-hot control vector, drives the BMU operands for one cycle, and captures the BMU's registered result/error. Returns the result in order on a valid/ready response channel with the original tag.

## Interface
- DEPTH, 4, request FIFO depth; power of two, ≥2
- TAG_W, 4, request/response tag width
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready; equals !fifo_full
- req_op  in  4  opcode, see Operation
- req_a, req_b  in  32  operands
- req_tag  in  TAG_W  request tag
- bmu_valid_in  out  1  BMU valid
- bmu_a_in, bmu_b_in  out  32  BMU operands
- bmu_ap  out  23  BMU control vector, MSB→LSB: csr_write, csr_imm, zbb, zbp, zba, zbs, land, lxor, sll, sra, rol, bext, sh3add, add, slt, unsign, sub, clz, cpop, siext_h, min, packu, gorc
- bmu_result_ff  in  32  BMU registered result
- bmu_error  in  1  BMU registered error
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_result  out  32  result
- rsp_error  out  1  error flag
- rsp_tag  out  TAG_W  tag of the completed request
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty
- err_cnt  out  16  error-response counter (see Configuration)

## Operation
- Opcode decode to bmu_ap bits set:
  - 0 ADD: add
  - 1 SUB: sub
  - 2 AND: land
  - 3 ANDN: land+zbb
  - 4 XOR: lxor
  - 5 SLL: sll
  - 6 SRA: sra
  - 7 BEXT: bext
  - 8 SLT: slt
  - 9 SLTU: slt+unsign
  - 10 CLZ: clz
  - 11 CPOP: cpop
  - 12 SEXTH: siext_h
  - 13 PACKU: packu
  - 14–15 illegal
- FIFO: a request is pushed on req_valid && req_ready. Entry contents: {op, a, b, tag}. FIFO full is tested before the same-cycle pop, so ready never depends on a pop.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if FIFO non-empty, pop the head into the op register. Legal opcode → ISSUE. Illegal opcode → RESP with result=0, error=1; the BMU is not touched.
  - ISSUE: bmu_valid_in=1; bmu_a_in/bmu_b_in/bmu_ap from the op register → CAPTURE.
  - CAPTURE: latch bmu_result_ff and bmu_error into the response registers → RESP.
  - RESP: rsp_valid=1. On rsp_ready → IDLE. Response outputs are held stable while stalled.
- Outside ISSUE: bmu_valid_in=0, bmu_ap=0, bmu_a_in=bmu_b_in=0.
- Responses are strictly in request order; one operation is in flight at a time.

## Timing
- Reset values (next edge with rst=1):
  - FIFO empty; FSM IDLE
  - req_ready=1
  - rsp_valid=0, rsp_result=0, rsp_error=0, rsp_tag=0
  - bmu_valid_in=0, bmu_ap=0, bmu_a_in=bmu_b_in=0
  - busy=0, err_cnt=0
- Latency: request accepted in cycle 0 → IDLE pops in cycle 1 → ISSUE cycle 2 → CAPTURE cycle 3 → rsp_valid in cycle 4.
- Back-to-back throughput: one response per 4 cycles with rsp_ready=1 (RESP→IDLE→ISSUE→CAPTURE→RESP).
- BMU contract: result/error are valid on bmu_result_ff/bmu_error exactly one cycle after the bmu_valid_in cycle.
- Capacity: DEPTH entries in the FIFO plus one in the FSM. req_ready falls after the DEPTH+1th acceptance while the response channel is stalled.
- Reset mid-operation: in-flight op and FIFO contents are discarded, no response is emitted, and bmu_valid_in is low from the next cycle.
- Push while FSM pops in the same cycle is allowed when not full.

## Configuration
- BMU_ISSUE_ERR_CNT_EN defined: err_cnt is a 16-bit counter incremented on each response handshake with rsp_error=1. It saturates at 0xFFFF and is cleared by rst.
- Not defined: err_cnt is tied to 0 and no counter logic is built.

## Test plan
- ADD a=0x7FFFFFFF b=0x00000001 tag=3 → single bmu_valid_in pulse with only the add bit set. Response result=0x80000000, error=1, tag=3, rsp_valid 4 cycles after acceptance.
- ANDN a=0xFF00FF00 b=0x0F0F0F0F → bmu_ap has land+zbb set. Response result=0xF000F000, error=0.
- SLT then SLTU, both with a=0xFFFFFFFF b=0x00000001 → responses 1 then 0, in order, tags preserved.
- Opcode 15 → no bmu_valid_in pulse; response result=0, error=1. err_cnt=1 when BMU_ISSUE_ERR_CNT_EN is defined, 0 otherwise.
- Hold rsp_ready=0 and stream XOR requests → req_ready drops after DEPTH+1 acceptances. Releasing rsp_ready drains all responses in order with correct results.
- Assert rst while in CAPTURE with 2 queued → rsp_valid stays 0, busy=0 next cycle, and a subsequent CPOP a=0x0000F00F returns 8.
